stack_pop_collector: RTL and testbench

- Multi-beat collector for RET/RTI stack pops. Assembles a PC_W-bit return PC, and optionally a FLAG_W-bit flags word, from consecutive DATA_W-bit memory read beats.
- Sits between the control state machine and the data-memory read port in the memory stage. Issues one read request per beat and hands the completed PC/flags to fetch and the flag register.
- Generalises the fixed 2×16-bit PC pop: word width, PC width and beat order are configurable, and memory read latency may be variable via a valid handshake.

---
 rtl/stack_pop_collector.sv | 133 +++++++++++++
 tb/tb_stack_pop_collector.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_pop_collector.sv
// stack_pop_collector: gathers a return PC (and, for RTI, a flags word)
// from consecutive data-memory read beats during a stack pop.
//
// Memory handshake: mem_rd_req is held high in REQ until mem_rd_ack is seen.
// mem_rd_valid then marks the cycle carrying the read data.
// Valid is honoured only in WAIT, or in REQ in the same cycle as ack.
// Valid at any other time is dropped.
//
// state_dbg exposes the FSM state: 0 IDLE, 1 REQ, 2 WAIT, 3 DONE.
module stack_pop_collector #(
    parameter int DATA_W     = 16,
    parameter int PC_W       = 32,
    parameter int FLAG_W     = 3,
    parameter bit LOW_FIRST  = 1'b1,
    parameter bit FLAGS_LAST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_rti,
    input  logic              flush,
    output logic              mem_rd_req,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              done,
    output logic [PC_W-1:0]   pc_out,
    output logic [FLAG_W-1:0] flags_out,
    output logic              flag_sel,
    output logic [1:0]        state_dbg
);

    localparam int NBEATS = PC_W / DATA_W;
    // Wide enough for total beat counts up to NBEATS + 1 = 9.
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] beat_cnt;
    logic          mode_q;

    logic [CW-1:0] last_idx;
    logic [CW-1:0] flag_idx;
    logic [CW-1:0] pc_idx;
    logic [CW-1:0] slice_idx;
    logic          beat_fire;
    logic          is_last;
    logic          is_flag;

    // Beat bookkeeping. Beat index k selects either the flags beat or PC slice j.
    // If the flags beat comes first, j lags k by one.
    always_comb begin
        last_idx  = CW'(NBEATS - 1) + CW'(mode_q);
        flag_idx  = FLAGS_LAST ? CW'(NBEATS) : '0;
        is_flag   = mode_q && (beat_cnt == flag_idx);
        pc_idx    = (mode_q && !FLAGS_LAST) ? beat_cnt - CW'(1) : beat_cnt;
        slice_idx = LOW_FIRST ? pc_idx : CW'(NBEATS - 1) - pc_idx;
        beat_fire = ((state == S_REQ) && mem_rd_ack && mem_rd_valid) ||
                    ((state == S_WAIT) && mem_rd_valid);
        is_last   = (beat_cnt == last_idx);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. Flush wins over any beat arriving in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_REQ;
            S_REQ: begin
                if (flush)            state_nxt = S_IDLE;
                else if (mem_rd_ack) begin
                    if (!mem_rd_valid) state_nxt = S_WAIT;
                    else if (is_last)  state_nxt = S_DONE;
                    else               state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (flush)             state_nxt = S_IDLE;
                else if (mem_rd_valid) state_nxt = is_last ? S_DONE : S_REQ;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        mem_rd_req = (state == S_REQ);
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        flag_sel   = (state == S_DONE) && mode_q;
        state_dbg  = state;
    end

    // Datapath: latch the mode on start and count beats.
    // Each beat is written in place into its PC slice or into the flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            mode_q    <= 1'b0;
            pc_out    <= '0;
            flags_out <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                mode_q   <= mode_rti;
                beat_cnt <= '0;
            end else if (beat_fire && !flush) begin
                if (!is_last) beat_cnt <= beat_cnt + CW'(1);
                if (is_flag) begin
                    flags_out <= mem_rd_data[FLAG_W-1:0];
                end else begin
                    for (int s = 0; s < NBEATS; s++) begin
                        if (slice_idx == CW'(s)) pc_out[s*DATA_W +: DATA_W] <= mem_rd_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stack_pop_collector.sv
// Bench for stack_pop_collector.
// Instance A uses the defaults: 16-bit beats, low slice first, flags last.
// Instance B uses 8-bit beats, high slice first, flags first.
// Both instances share the memory-side stimulus. sel_b chooses which one
// receives start and which one's outputs are observed.
module tb_stack_pop_collector;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst, start, mode_rti, flush, ack, valid;
    logic [15:0] data;
    logic        sel_b;

    wire start_a = start & ~sel_b;
    wire start_b = start & sel_b;

    logic        req_a, busy_a, done_a, flag_sel_a;
    logic [31:0] pc_a;
    logic [2:0]  flags_a;
    logic [1:0]  st_a;

    logic        req_b, busy_b, done_b, flag_sel_b;
    logic [31:0] pc_b;
    logic [2:0]  flags_b;
    logic [1:0]  st_b;

    stack_pop_collector #(
        .DATA_W(16), .PC_W(32), .FLAG_W(3), .LOW_FIRST(1'b1), .FLAGS_LAST(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode_rti(mode_rti), .flush(flush),
        .mem_rd_req(req_a), .mem_rd_ack(ack), .mem_rd_valid(valid), .mem_rd_data(data),
        .busy(busy_a), .done(done_a), .pc_out(pc_a), .flags_out(flags_a),
        .flag_sel(flag_sel_a), .state_dbg(st_a)
    );

    stack_pop_collector #(
        .DATA_W(8), .PC_W(32), .FLAG_W(3), .LOW_FIRST(1'b0), .FLAGS_LAST(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode_rti(mode_rti), .flush(flush),
        .mem_rd_req(req_b), .mem_rd_ack(ack), .mem_rd_valid(valid), .mem_rd_data(data[7:0]),
        .busy(busy_b), .done(done_b), .pc_out(pc_b), .flags_out(flags_b),
        .flag_sel(flag_sel_b), .state_dbg(st_b)
    );

    wire        req_o  = sel_b ? req_b  : req_a;
    wire        busy_o = sel_b ? busy_b : busy_a;
    wire        done_o = sel_b ? done_b : done_a;
    wire [31:0] pc_o   = sel_b ? pc_b   : pc_a;

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model / scoreboard ----------------
    // The model holds the architectural pc/flags per instance. Each beat is
    // applied as it is delivered, and results are queued for the done monitor.
    logic [31:0] m_pc [2];
    logic [2:0]  m_fl [2];
    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];
    logic [3:0]  exp_f_q_a[$];
    logic [3:0]  exp_f_q_b[$];

    logic [31:0] mon_pc_a, mon_pc_b;
    logic [3:0]  mon_f_a, mon_f_b;

    // Each done pulse must match exactly one expected completion.
    always @(negedge clk) begin
        if (done_a) begin
            if (exp_q_a.size() == 0) chk("spurious_done_a", 32'd1, 32'd0);
            else begin
                mon_pc_a = exp_q_a.pop_front();
                mon_f_a  = exp_f_q_a.pop_front();
                chk("pc_at_done_a", pc_a, mon_pc_a);
                chk("flags_at_done_a", 32'(flags_a), 32'(mon_f_a[2:0]));
                chk("flag_sel_a", 32'(flag_sel_a), 32'(mon_f_a[3]));
            end
        end
        if (done_b) begin
            if (exp_q_b.size() == 0) chk("spurious_done_b", 32'd1, 32'd0);
            else begin
                mon_pc_b = exp_q_b.pop_front();
                mon_f_b  = exp_f_q_b.pop_front();
                chk("pc_at_done_b", pc_b, mon_pc_b);
                chk("flags_at_done_b", 32'(flags_b), 32'(mon_f_b[2:0]));
                chk("flag_sel_b", 32'(flag_sel_b), 32'(mon_f_b[3]));
            end
        end
    end

    // ---------------- driver ----------------
    // One pop sequence. Each beat gets ack ad cycles after req is first seen.
    // Valid follows vd cycles after ack; vd = 0 means valid arrives with ack.
    // flush_after >= 0 aborts the sequence after that many beats.
    // poke raises start during the first beat to show it is ignored.
    task automatic run_seq(input bit inst, input bit rti, input int ad, input int vd,
                           input int flush_after, input bit poke,
                           input logic [15:0] bv[9], input bit use_bv);
        int          nb    = inst ? 4 : 2;
        int          dw    = inst ? 8 : 16;
        bit          lf    = inst ? 1'b0 : 1'b1;
        bit          fl    = inst ? 1'b0 : 1'b1;
        int          total = nb + int'(rti);
        int          j     = 0;
        int          t0;
        int          sh;
        logic [15:0] beat;
        logic [31:0] mask  = inst ? 32'h0000_00FF : 32'h0000_FFFF;

        @(negedge clk);
        sel_b = inst; start = 1'b1; mode_rti = rti; t0 = cyc;
        @(negedge clk);
        start = 1'b0; mode_rti = 1'($urandom);
        chk("busy_after_start", 32'(busy_o), 32'd1);

        for (int k = 0; k < total; k++) begin
            if (k == flush_after) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                chk("flush_idle", 32'(busy_o), 32'd0);
                chk("flush_req_drop", 32'(req_o), 32'd0);
                valid = 1'b1; data = 16'($urandom);
                @(negedge clk);
                valid = 1'b0;
                chk("late_valid_ignored", pc_o, m_pc[inst]);
                return;
            end
            for (int d = 0; d < ad; d++) begin
                chk("req_held", 32'(req_o), 32'd1);
                @(negedge clk);
            end
            chk("req_at_ack", 32'(req_o), 32'd1);

            beat = use_bv ? bv[k] : 16'($urandom);
            if (rti && k == (fl ? nb : 0)) begin
                m_fl[inst] = beat[2:0];
            end else begin
                sh = (lf ? j : nb - 1 - j) * dw;
                m_pc[inst] = (m_pc[inst] & ~(mask << sh)) | ((32'(beat) & mask) << sh);
                j++;
            end
            if (k == total - 1) begin
                if (inst) begin exp_q_b.push_back(m_pc[1]); exp_f_q_b.push_back({rti, m_fl[1]}); end
                else      begin exp_q_a.push_back(m_pc[0]); exp_f_q_a.push_back({rti, m_fl[0]}); end
            end

            ack = 1'b1; data = beat; valid = (vd == 0);
            if (poke && k == 0) start = 1'b1;
            @(negedge clk);
            ack = 1'b0; valid = 1'b0; start = 1'b0;
            if (vd > 0) begin
                for (int d = 1; d < vd; d++) begin
                    chk("req_low_in_wait", 32'(req_o), 32'd0);
                    chk("busy_in_wait", 32'(busy_o), 32'd1);
                    data = 16'($urandom);
                    @(negedge clk);
                end
                valid = 1'b1; data = beat;
                @(negedge clk);
                valid = 1'b0;
            end
        end

        // Immediate ack and valid: one edge takes start, then one edge per beat.
        // That is start..done inclusive of total + 2 cycles.
        if (ad == 0 && vd == 0) chk("latency", 32'(cyc - t0), 32'(total + 1));
        chk("done_high", 32'(done_o), 32'd1);
        chk("busy_in_done", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_o), 32'd0);
        chk("idle_after_done", 32'(busy_o), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [15:0] bv[9];
    logic [15:0] none[9];

    initial begin
        rst = 1'b1; start = 1'b0; mode_rti = 1'b0; flush = 1'b0;
        ack = 1'b0; valid = 1'b0; data = '0; sel_b = 1'b0;
        for (int i = 0; i < 9; i++) none[i] = '0;
        m_pc[0] = '0; m_pc[1] = '0; m_fl[0] = '0; m_fl[1] = '0;
        repeat (3) @(negedge clk);
        chk("rst_pc_a", pc_a, 32'd0);
        chk("rst_flags_a", 32'(flags_a), 32'd0);
        chk("rst_outs_a", {28'd0, req_a, busy_a, done_a, flag_sel_a}, 32'd0);
        chk("rst_state_a", 32'(st_a), 32'd0);
        chk("rst_outs_b", {28'd0, req_b, busy_b, done_b, flag_sel_b}, 32'd0);
        rst = 1'b0;

        // RET, immediate memory: 0x1234 then 0xABCD.
        bv = none; bv[0] = 16'h1234; bv[1] = 16'hABCD;
        run_seq(1'b0, 1'b0, 0, 0, -1, 1'b0, bv, 1'b1);
        chk("ret_pc", pc_a, 32'hABCD_1234);
        chk("ret_flags_kept", 32'(flags_a), 32'd0);

        // RTI, flags after PC.
        bv = none; bv[0] = 16'h0010; bv[1] = 16'h0000; bv[2] = 16'hFFF5;
        run_seq(1'b0, 1'b1, 0, 0, -1, 1'b0, bv, 1'b1);
        chk("rti_pc", pc_a, 32'h0000_0010);
        chk("rti_flags", 32'(flags_a), 32'h5);

        // Variable latency, with a start while busy.
        bv = none; bv[0] = 16'h1234; bv[1] = 16'hABCD;
        run_seq(1'b0, 1'b0, 2, 3, -1, 1'b1, bv, 1'b1);
        chk("varlat_pc", pc_a, 32'hABCD_1234);
        chk("varlat_flags_kept", 32'(flags_a), 32'h5);

        // 8-bit beats, high slice first.
        bv = none; bv[0] = 16'h11; bv[1] = 16'h22; bv[2] = 16'h33; bv[3] = 16'h44;
        run_seq(1'b1, 1'b0, 0, 0, -1, 1'b0, bv, 1'b1);
        chk("msb_first_pc", pc_b, 32'h1122_3344);

        // 8-bit RTI, flags first.
        bv = none; bv[0] = 16'h06; bv[1] = 16'hDE; bv[2] = 16'hAD; bv[3] = 16'hBE; bv[4] = 16'hEF;
        run_seq(1'b1, 1'b1, 1, 1, -1, 1'b0, bv, 1'b1);
        chk("flags_first_pc", pc_b, 32'hDEAD_BEEF);
        chk("flags_first_flags", 32'(flags_b), 32'h6);

        // Flush after the first beat, then a clean RET.
        run_seq(1'b0, 1'b0, 0, 1, 1, 1'b0, none, 1'b0);
        bv = none; bv[0] = 16'hC0DE; bv[1] = 16'h0042;
        run_seq(1'b0, 1'b0, 0, 0, -1, 1'b0, bv, 1'b1);
        chk("after_flush_pc", pc_a, 32'h0042_C0DE);

        // Reset in WAIT together with valid: the beat must not land.
        @(negedge clk);
        sel_b = 1'b0; start = 1'b1; mode_rti = 1'b1;
        @(negedge clk);
        start = 1'b0; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("wait_busy", 32'(busy_a), 32'd1);
        chk("wait_req_low", 32'(req_a), 32'd0);
        rst = 1'b1; valid = 1'b1; data = 16'h5A5A;
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        chk("rst_wait_pc", pc_a, 32'd0);
        chk("rst_wait_flags", 32'(flags_a), 32'd0);
        chk("rst_wait_outs", {28'd0, req_a, busy_a, done_a, flag_sel_a}, 32'd0);
        chk("rst_wait_state", 32'(st_a), 32'd0);
        m_pc[0] = '0; m_pc[1] = '0; m_fl[0] = '0; m_fl[1] = '0;

        // Randomised sequences on both instances.
        for (int n = 0; n < 60; n++) begin
            bit inst;
            bit rti;
            int tot;
            int fa;
            inst = 1'($urandom);
            rti  = 1'($urandom);
            tot  = (inst ? 4 : 2) + int'(rti);
            fa   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, tot - 1)) : -1;
            run_seq(inst, rti, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    fa, 1'($urandom_range(0, 3) == 0), none, 1'b0);
            chk("rand_pc", pc_o, m_pc[inst]);
            chk("rand_flags", 32'(inst ? flags_b : flags_a), 32'(m_fl[inst]));
        end

        repeat (3) @(negedge clk);
        chk("pending_done_a", 32'(exp_q_a.size()), 32'd0);
        chk("pending_done_b", 32'(exp_q_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
